iddmm_row_engine: RTL and testbench
===================================

Name: iddmm_row_engine

Overview:
- Parametrised word-serial Montgomery row engine. Executes one outer iteration of the CIOS-style interleaved modular multiply: A' = (A + x_i*Y + q*P) / 2^K, with q = (s_0 * p1) mod 2^K.
- Sits between the word memories and the exponentiation controller.
- Successor of the fixed 128-bit row datapath, with these additions:
  - generic K, N and multiplier latency;
  - valid-tagged stream handshake with no j_cnt sentinels;
  - automatic top-word flush and per-row carry reset;
  - back-to-back rows and a q-consistency error flag.

Parameters:
K, 128, word width in bits.
N, 32, words per operand (N >= 2).
MUL_LAT, 8, register stages inside each internal KxK multiplier (>= 1).
ADDR_W, max(1,$clog2(N)), word-index width.

Ports:
clk  in  1  clock.
rst_n  in  1  reset, asynchronous, active-low.
in_valid  in  1  input word valid.
in_ready  out  1  engine accepts a word this cycle.
in_x  in  K  multiplier word x_i; sampled on word 0.
in_p1  in  K  -P^-1 mod 2^K; sampled on word 0.
in_y  in  K  Y word j.
in_a  in  K  accumulator word a_j.
in_p  in  K  modulus word p_j.
in_a_hi  in  1  accumulator top bit a_N; sampled on word N-1.
out_valid  out  1  result word valid.
out_idx  out  ADDR_W  index of the result word (0..N-1).
out_data  out  K  result word.
out_last  out  1  high with out_idx = N-1.
out_hi  out  1  result top bit; valid with out_last.
err_q  out  1  one-cycle pulse: low K bits of word-0 sum were nonzero.
busy  out  1  any element in flight.

Behaviour:
- Reset: all outputs 0. Word counter, pipeline valids, q and carry cleared. in_ready = 1 one cycle after reset release. Reset mid-row discards all in-flight data; no partial output.
- Acceptance is in_valid & in_ready. Gaps between words are allowed.
- Internal counter j runs 0..N-1. Acceptance at j = N-1 wraps j to 0.
- Flush cycle: in the cycle after word N-1 is accepted, in_ready = 0 and the engine injects element j = N with y = 0, p = 0, a = sampled a_hi. in_ready returns to 1 the next cycle. A new row's word 0 may follow immediately (back-to-back rows).
- Stage A: s_j = x_i*y_j + a_j (2K bits). Product takes MUL_LAT cycles, then +1 registered add.
- Stage B: q = (p1 * s_0) mod 2^K (MUL_LAT cycles). The q register updates only when the j = 0 element exits stage B, and is held otherwise. Elements of the previous row are already past the q consumer.
- All elements are delayed to stay aligned with q: the stage-B delay applies to every element.
- Stage C:
  - acc_j = q*p_j + s_j + c, with c = 0 when j = 0 and c = acc_{j-1} >> K otherwise.
  - acc is 2K+1 bits. Product takes MUL_LAT cycles, then +1 register.
- Output register:
  - j = 0: no out_valid. err_q = 1 if acc_0[K-1:0] != 0.
  - 1 <= j <= N: out_valid = 1, out_idx = j-1, out_data = acc_j[K-1:0].
  - j = N additionally: out_last = 1, out_hi = acc_N[K]. Bits above K are discarded (the precondition A < 2P guarantees they are 0).
  - Otherwise out_valid, out_idx, out_data, out_last, out_hi are 0.
- Latency: LAT = 3*MUL_LAT + 4 cycles from acceptance of word j (j >= 1) to out_valid for out_idx = j-1. The flush element outputs LAT cycles after its injection cycle.
- No output backpressure: the consumer must take every out_valid word.
- busy = OR of all pipeline valid bits, or j != 0.

Test Plan (K=8, N=2, MUL_LAT=2, LAT=10):
1. x=0x01, Y={0x00,0x01}, A={0,0}, a_hi=0, P={0x00,0xFF}, p1=0x01, words at cycles t, t+1 -> out idx0 = 0x01 at t+11; idx1 = 0x00, out_last=1, out_hi=0 at t+12; err_q stays 0.
2. Max carry: x=0xFF, Y={0xFF,0xFF}, A={0xFF,0xFF}, a_hi=0, P={0xFF,0xFF}, p1=0x01 -> out 0xFF, 0xFF, out_hi=0.
3. Same as 2 with a_hi=1 -> out 0xFF, 0x00, out_hi=1.
4. Back-to-back rows:
   - Stimulus: row of scenario 1 then row of scenario 3, in_valid held high.
   - in_ready must be low exactly at t+2 and t+5.
   - Outputs must be 0x01, 0x00 then 0xFF, 0x00 with out_hi=1, each in correct cycles.
   - Checks q re-capture per row and carry reset at j=0.
5. Wrong p1 = 0x00 with stimulus of scenario 1 -> err_q pulses once at t+10.
6. Reset asserted at t+5 during a row -> all outputs 0 immediately; no out_valid after release; the next row computes as in scenario 1.

Source files
------------

// File: rtl/iddmm_row_engine.sv
// rtl/iddmm_row_engine.sv - word-serial Montgomery row engine computing (A + x*Y + q*P) / 2^K
// Each accepted word (plus one injected flush element) walks a fixed-latency pipeline: x*y+a, q capture, q*p+s+carry.
module iddmm_row_engine #(
  parameter int K       = 128,
  parameter int N       = 32,
  parameter int MUL_LAT = 8,
  parameter int ADDR_W  = (N <= 2) ? 1 : $clog2(N)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [K-1:0]      in_x,
  input  logic [K-1:0]      in_p1,
  input  logic [K-1:0]      in_y,
  input  logic [K-1:0]      in_a,
  input  logic [K-1:0]      in_p,
  input  logic              in_a_hi,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_idx,
  output logic [K-1:0]      out_data,
  output logic              out_last,
  output logic              out_hi,
  output logic              err_q,
  output logic              busy
);

  localparam int M  = MUL_LAT;
  localparam int JW = $clog2(N + 1);
  localparam int W2 = 2 * K;
  localparam int W1 = 2 * K + 1;

  logic [ADDR_W-1:0] j_cnt;
  logic              ready_r, flush_r, a_hi_r;
  logic [K-1:0]      x_r, p1_r;
  logic              accept, last_word;

  assign accept    = in_valid & ready_r;
  assign last_word = (j_cnt == ADDR_W'(N - 1));
  assign in_ready  = ready_r;

  // Element entry register: accepted word or the synthetic top-word flush element.
  logic          v0;
  logic [JW-1:0] j0;
  logic [K-1:0]  x0, p1_0, y0, a0, pw0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      j_cnt   <= '0;
      ready_r <= 1'b0;
      flush_r <= 1'b0;
      a_hi_r  <= 1'b0;
      x_r     <= '0;
      p1_r    <= '0;
      v0      <= 1'b0;
      j0      <= '0;
      x0      <= '0;
      p1_0    <= '0;
      y0      <= '0;
      a0      <= '0;
      pw0     <= '0;
    end else begin
      ready_r <= !(accept && last_word);
      flush_r <= accept && last_word;
      v0      <= accept | flush_r;
      if (accept) begin
        j_cnt <= last_word ? '0 : j_cnt + 1'b1;
        if (last_word) a_hi_r <= in_a_hi;
        if (j_cnt == '0) begin
          x_r  <= in_x;
          p1_r <= in_p1;
        end
        j0   <= JW'(j_cnt);
        x0   <= (j_cnt == '0) ? in_x : x_r;
        p1_0 <= (j_cnt == '0) ? in_p1 : p1_r;
        y0   <= in_y;
        a0   <= in_a;
        pw0  <= in_p;
      end else if (flush_r) begin
        j0   <= JW'(N);
        x0   <= x_r;
        p1_0 <= p1_r;
        y0   <= '0;
        a0   <= {{(K-1){1'b0}}, a_hi_r};
        pw0  <= '0;
      end
    end
  end

  // Stage A: s = x*y + a
  logic [M-1:0]  va;
  logic [JW-1:0] ja  [M];
  logic [W2-1:0] pa  [M];
  logic [K-1:0]  aa  [M];
  logic [K-1:0]  pwa [M];
  logic [K-1:0]  p1a [M];
  logic          vs;
  logic [JW-1:0] js;
  logic [W2-1:0] s;
  logic [K-1:0]  pws, p1s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      va  <= '0;
      vs  <= 1'b0;
      js  <= '0;
      s   <= '0;
      pws <= '0;
      p1s <= '0;
      for (int i = 0; i < M; i++) begin
        ja[i]  <= '0;
        pa[i]  <= '0;
        aa[i]  <= '0;
        pwa[i] <= '0;
        p1a[i] <= '0;
      end
    end else begin
      va[0]  <= v0;
      ja[0]  <= j0;
      pa[0]  <= W2'(x0) * W2'(y0);
      aa[0]  <= a0;
      pwa[0] <= pw0;
      p1a[0] <= p1_0;
      for (int i = 1; i < M; i++) begin
        va[i]  <= va[i-1];
        ja[i]  <= ja[i-1];
        pa[i]  <= pa[i-1];
        aa[i]  <= aa[i-1];
        pwa[i] <= pwa[i-1];
        p1a[i] <= p1a[i-1];
      end
      vs  <= va[M-1];
      js  <= ja[M-1];
      s   <= pa[M-1] + W2'(aa[M-1]);
      pws <= pwa[M-1];
      p1s <= p1a[M-1];
    end
  end

  // Stage B: q = p1*s mod 2^K; every element takes the same delay so it meets its row's q.
  logic [M-1:0]  vb;
  logic [JW-1:0] jb  [M];
  logic [K-1:0]  qb  [M];
  logic [W2-1:0] sb  [M];
  logic [K-1:0]  pwb [M];
  logic [K-1:0]  q_r, q_eff;

  always_comb begin
    q_eff = q_r;
    if (jb[M-1] == '0) q_eff = qb[M-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vb  <= '0;
      q_r <= '0;
      for (int i = 0; i < M; i++) begin
        jb[i]  <= '0;
        qb[i]  <= '0;
        sb[i]  <= '0;
        pwb[i] <= '0;
      end
    end else begin
      vb[0]  <= vs;
      jb[0]  <= js;
      qb[0]  <= p1s * s[K-1:0];
      sb[0]  <= s;
      pwb[0] <= pws;
      for (int i = 1; i < M; i++) begin
        vb[i]  <= vb[i-1];
        jb[i]  <= jb[i-1];
        qb[i]  <= qb[i-1];
        sb[i]  <= sb[i-1];
        pwb[i] <= pwb[i-1];
      end
      if (vb[M-1] && jb[M-1] == '0) q_r <= q_eff;
    end
  end

  // Stage C: acc = q*p + s + carry, carry chain restarts at word 0.
  logic [M-1:0]  vc;
  logic [JW-1:0] jc [M];
  logic [W2-1:0] pc [M];
  logic [W2-1:0] sc [M];
  logic          vacc;
  logic [JW-1:0] jacc;
  logic [W1-1:0] acc;
  logic [K:0]    carry;

  always_comb begin
    carry = '0;
    if (jc[M-1] != '0) carry = acc[W1-1:K];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vc   <= '0;
      vacc <= 1'b0;
      jacc <= '0;
      acc  <= '0;
      for (int i = 0; i < M; i++) begin
        jc[i] <= '0;
        pc[i] <= '0;
        sc[i] <= '0;
      end
    end else begin
      vc[0] <= vb[M-1];
      jc[0] <= jb[M-1];
      pc[0] <= W2'(q_eff) * W2'(pwb[M-1]);
      sc[0] <= sb[M-1];
      for (int i = 1; i < M; i++) begin
        vc[i] <= vc[i-1];
        jc[i] <= jc[i-1];
        pc[i] <= pc[i-1];
        sc[i] <= sc[i-1];
      end
      vacc <= vc[M-1];
      // acc holds across gaps so the carry survives until the next word arrives
      if (vc[M-1]) begin
        jacc <= jc[M-1];
        acc  <= W1'(pc[M-1]) + W1'(sc[M-1]) + W1'(carry);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_idx   <= '0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_hi    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      out_idx   <= '0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_hi    <= 1'b0;
      err_q     <= 1'b0;
      if (vacc) begin
        if (jacc == '0) begin
          err_q <= (acc[K-1:0] != '0);
        end else begin
          out_valid <= 1'b1;
          out_idx   <= ADDR_W'(jacc - JW'(1));
          out_data  <= acc[K-1:0];
          if (jacc == JW'(N)) begin
            out_last <= 1'b1;
            out_hi   <= acc[K];
          end
        end
      end
    end
  end

  assign busy = flush_r | v0 | (|va) | vs | (|vb) | (|vc) | vacc | (j_cnt != '0);

endmodule

// File: tb/tb_iddmm_row_engine.sv
// tb/tb_iddmm_row_engine.sv - scoreboard bench for iddmm_row_engine (K=8, N=2, MUL_LAT=2)
module tb_iddmm_row_engine;
  localparam int K = 8, N = 2, ML = 2, AW = 1, LAT = 3 * ML + 4;

  typedef int wv_t [N];
  typedef struct { int cyc; int idx; int data; int last; int hi; } exp_t;

  logic clk = 1'b0, rst_n = 1'b0;
  logic in_valid, in_ready, in_a_hi;
  logic [K-1:0] in_x, in_p1, in_y, in_a, in_p;
  logic out_valid, out_last, out_hi, err_q, busy;
  logic [AW-1:0] out_idx;
  logic [K-1:0] out_data;

  always #5 clk = ~clk;

  iddmm_row_engine #(.K(K), .N(N), .MUL_LAT(ML), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_p1(in_p1), .in_y(in_y), .in_a(in_a), .in_p(in_p), .in_a_hi(in_a_hi),
    .out_valid(out_valid), .out_idx(out_idx), .out_data(out_data), .out_last(out_last),
    .out_hi(out_hi), .err_q(err_q), .busy(busy)
  );

  int cyc = 0;
  int total = 0, bad = 0;
  exp_t oq[$];
  int eq[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: whole-number Montgomery step on the assembled operands.
  task automatic model_row(input int x, input int p1, input int a_hi,
                           input wv_t y, input wv_t a, input wv_t p, input wv_t c);
    longint av, yv, pv, t, r;
    int s0, q;
    exp_t e;
    av = longint'(a_hi) << (K * N);
    yv = 0;
    pv = 0;
    for (int j = 0; j < N; j++) begin
      av += longint'(a[j]) << (K * j);
      yv += longint'(y[j]) << (K * j);
      pv += longint'(p[j]) << (K * j);
    end
    s0 = (x * y[0] + a[0]) % 256;
    q  = (p1 * s0) % 256;
    t  = av + longint'(x) * yv + longint'(q) * pv;
    r  = t >> K;
    for (int i = 0; i < N; i++) begin
      e.cyc  = (i < N - 1) ? c[i+1] + LAT : c[N-1] + 1 + LAT;
      e.idx  = i;
      e.data = int'((r >> (K * i)) & 255);
      e.last = (i == N - 1) ? 1 : 0;
      e.hi   = (i == N - 1) ? int'((r >> (K * N)) & 1) : 0;
      oq.push_back(e);
    end
    if ((t & 255) != 0) eq.push_back(c[0] + LAT);
  endtask

  task automatic send_word(output int c);
    in_valid = 1'b1;
    c = -1000;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (in_ready) begin
        c = cyc;
        break;
      end
    end
    if (c < 0) chk("accept_timeout", 0, 1);
    else begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_row(input int x, input int p1, input int a_hi,
                          input wv_t y, input wv_t a, input wv_t p,
                          input int gapmax, input bit keep, input bit push,
                          output int c0, output int cl);
    wv_t c;
    int cc, g;
    for (int j = 0; j < N; j++) begin
      if (gapmax > 0) begin
        g = $urandom_range(0, gapmax);
        if (g > 0) begin
          in_valid = 1'b0;
          repeat (g) @(posedge clk);
          #1;
        end
      end
      in_x    = (j == 0) ? 8'(x) : 8'($urandom);
      in_p1   = (j == 0) ? 8'(p1) : 8'($urandom);
      in_y    = 8'(y[j]);
      in_a    = 8'(a[j]);
      in_p    = 8'(p[j]);
      in_a_hi = (j == N - 1) ? 1'(a_hi) : 1'($urandom);
      send_word(cc);
      c[j] = cc;
    end
    chk("flush_in_ready", in_ready, 0);
    if (!keep) in_valid = 1'b0;
    if (push) model_row(x, p1, a_hi, y, a, p, c);
    c0 = c[0];
    cl = c[N-1];
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n) begin
      if (oq.size() > 0 && oq[0].cyc < cyc) begin
        chk("missed_out", cyc, oq[0].cyc);
        oq.delete(0);
      end
      if (eq.size() > 0 && eq[0] < cyc) begin
        chk("missed_err_q", cyc, eq[0]);
        eq.delete(0);
      end
      if (out_valid) begin
        if (oq.size() == 0) chk("unexpected_out", 1, 0);
        else begin
          e = oq.pop_front();
          chk("out_cycle", cyc, e.cyc);
          chk("out_idx", out_idx, e.idx);
          chk("out_data", out_data, e.data);
          chk("out_last", out_last, e.last);
          chk("out_hi", out_hi, e.hi);
        end
      end else begin
        chk("idle_fields", {out_idx, out_data, out_last, out_hi}, 0);
      end
      if (err_q) begin
        if (eq.size() == 0) chk("unexpected_err_q", 1, 0);
        else chk("err_q_cycle", cyc, eq.pop_front());
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    wv_t y1, a1, p1v, yf, af, pf, yr, ar, pr;
    int c0, cl, c0b, clb, x, p1, ah, inv;

    in_valid = 1'b0; in_x = '0; in_p1 = '0; in_y = '0; in_a = '0; in_p = '0; in_a_hi = 1'b0;
    y1  = '{8'h01, 8'h00};
    a1  = '{0, 0};
    p1v = '{8'hFF, 8'h00};
    yf  = '{8'hFF, 8'hFF};
    af  = '{8'hFF, 8'hFF};
    pf  = '{8'hFF, 8'hFF};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out", {out_valid, out_idx, out_data, out_last, out_hi, err_q}, 0);
    rst_n = 1'b1;
    chk("rel_in_ready_same_cycle", in_ready, 0);
    @(posedge clk);
    #1;
    chk("rel_in_ready_next", in_ready, 1);

    // Scenarios 1-3
    send_row(1, 1, 0, y1, a1, p1v, 0, 0, 1, c0, cl);
    chk("s1_word_spacing", cl - c0, 1);
    repeat (LAT + 4) @(posedge clk);
    #1;
    chk("s1_idle_busy", busy, 0);
    send_row(8'hFF, 1, 0, yf, af, pf, 0, 0, 1, c0, cl);
    repeat (3) @(posedge clk);
    #1;
    send_row(8'hFF, 1, 1, yf, af, pf, 0, 0, 1, c0, cl);
    repeat (LAT + 4) @(posedge clk);
    #1;

    // Scenario 4: back-to-back rows with in_valid held high
    send_row(1, 1, 0, y1, a1, p1v, 0, 1, 1, c0, cl);
    send_row(8'hFF, 1, 1, yf, af, pf, 0, 0, 1, c0b, clb);
    chk("b2b_row2_start", c0b - c0, 3);
    chk("b2b_row2_end", clb - c0, 4);
    repeat (LAT + 4) @(posedge clk);
    #1;

    // Scenario 5: wrong p1 makes the low word of acc_0 nonzero
    send_row(1, 0, 0, y1, a1, p1v, 0, 0, 1, c0, cl);
    repeat (LAT + 4) @(posedge clk);
    #1;

    // Scenario 6: reset in the middle of a row
    send_row(1, 1, 0, y1, a1, p1v, 0, 0, 0, c0, cl);
    while (cyc < c0 + 5) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    #1;
    chk("midrst_out", {out_valid, out_idx, out_data, out_last, out_hi, err_q}, 0);
    chk("midrst_in_ready", in_ready, 0);
    chk("midrst_busy", busy, 0);
    oq.delete();
    eq.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (LAT + 5) @(posedge clk);
    #1;
    chk("postrst_busy", busy, 0);
    send_row(1, 1, 0, y1, a1, p1v, 0, 0, 1, c0, cl);
    repeat (LAT + 4) @(posedge clk);
    #1;

    // Random rows with random gaps; p1 usually the true -P0^-1
    for (int r = 0; r < 40; r++) begin
      x = $urandom_range(0, 255);
      ah = $urandom_range(0, 1);
      for (int j = 0; j < N; j++) begin
        yr[j] = $urandom_range(0, 255);
        ar[j] = $urandom_range(0, 255);
        pr[j] = $urandom_range(0, 255);
      end
      if ($urandom_range(0, 3) != 0) begin
        pr[0] = pr[0] | 1;
        inv = 0;
        for (int v = 0; v < 256; v++) if (((pr[0] * v) & 255) == 1) inv = v;
        p1 = (256 - inv) & 255;
      end else begin
        p1 = $urandom_range(0, 255);
      end
      send_row(x, p1, ah, yr, ar, pr, $urandom_range(0, 2), $urandom_range(0, 1), 1, c0, cl);
    end
    in_valid = 1'b0;
    repeat (LAT + 6) @(posedge clk);
    #1;
    chk("final_out_queue_empty", oq.size(), 0);
    chk("final_err_queue_empty", eq.size(), 0);
    chk("final_busy", busy, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
